iserdes_align_ctrl: RTL and testbench

ISERDES_ALIGN_CTRL -- requirements
Module: iserdes_align_ctrl

---
 rtl/iserdes_align_ctrl.sv | 157 +++++++++++++++
 tb/tb_iserdes_align_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/iserdes_align_ctrl.sv
//------------------------------------------------------------------------------
// Module      : iserdes_align_ctrl
// Description : Word-alignment controller for a deserializer using a training
//               word, with either hardware bitslip or internal rotation.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iserdes_align_ctrl #(
    parameter int          C_DATA_WIDTH    = 8,
    parameter logic [7:0]  C_TRAIN_PATTERN = 8'h5C,
    parameter string       C_SLIP_MODE     = "HW",
    parameter int          C_WAIT_CYCLES   = 4,
    parameter int          C_LOCK_CNT      = 16,
    parameter int          C_LOSE_CNT      = 4
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       bitslip_o,
    output logic [7:0] data_o,
    output logic       data_vld_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [3:0] slip_cnt_o
);

    localparam int                C_W         = C_DATA_WIDTH;
    localparam int                C_RW        = (C_W > 4) ? 3 : 2;
    localparam bit                C_SOFT      = (C_SLIP_MODE == "SOFT");
    localparam logic [C_W-1:0]    C_PAT       = C_TRAIN_PATTERN[C_W-1:0];
    localparam logic [3:0]        C_LAST_SLIP = 4'(C_W - 1);
    localparam logic [7:0]        C_LOCK_LAST = 8'(C_LOCK_CNT - 1);
    localparam logic [3:0]        C_LOSE_LAST = 4'(C_LOSE_CNT - 1);
    localparam logic [3:0]        C_WAIT_LAST = 4'(C_WAIT_CYCLES - 1);
    localparam logic [C_RW-1:0]   C_ROT_LAST  = C_RW'(C_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SLIP   = 3'd2,
        S_WAIT   = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t          r_state;
    logic [C_W-1:0]  r_prev;
    logic [C_RW-1:0] r_rot;
    logic [7:0]      r_match_cnt;
    logic [3:0]      r_miss_cnt;
    logic [3:0]      r_wait_cnt;

    logic [2*C_W-1:0] w_window;
    logic [C_W-1:0]   w_aligned;
    logic             w_match;

    // Soft mode picks a W-bit window spanning the current and previous words.
    assign w_window  = {data_i[C_W-1:0], r_prev};
    assign w_aligned = C_SOFT ? w_window[r_rot +: C_W] : data_i[C_W-1:0];
    assign w_match   = (w_aligned == C_PAT);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= S_IDLE;
            r_prev      <= '0;
            r_rot       <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_wait_cnt  <= '0;
            bitslip_o   <= 1'b0;
            data_o      <= '0;
            data_vld_o  <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
            slip_cnt_o  <= '0;
        end else begin
            r_prev    <= data_i[C_W-1:0];
            data_o    <= 8'(w_aligned);
            bitslip_o <= 1'b0;
            if (start_i) begin
                r_state     <= S_CHECK;
                r_rot       <= '0;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
                r_wait_cnt  <= '0;
                slip_cnt_o  <= '0;
                fail_o      <= 1'b0;
                locked_o    <= 1'b0;
                data_vld_o  <= 1'b0;
            end else begin
                case (r_state)
                    S_CHECK: begin
                        if (w_match) begin
                            if (r_match_cnt != 8'hFF)
                                r_match_cnt <= r_match_cnt + 8'd1;
                            if (r_match_cnt >= C_LOCK_LAST) begin
                                r_state    <= S_LOCKED;
                                r_miss_cnt <= '0;
                                locked_o   <= 1'b1;
                                data_vld_o <= 1'b1;
                            end
                        end else begin
                            r_match_cnt <= '0;
                            if (slip_cnt_o == C_LAST_SLIP) begin
                                r_state <= S_FAIL;
                                fail_o  <= 1'b1;
                            end else begin
                                r_state   <= S_SLIP;
                                bitslip_o <= ~C_SOFT;
                            end
                        end
                    end
                    S_SLIP: begin
                        if (slip_cnt_o != 4'hF)
                            slip_cnt_o <= slip_cnt_o + 4'd1;
                        if (C_SOFT)
                            r_rot <= (r_rot == C_ROT_LAST) ? '0 : r_rot + C_RW'(1);
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (r_wait_cnt >= C_WAIT_LAST) begin
                            r_state     <= S_CHECK;
                            r_match_cnt <= '0;
                            r_wait_cnt  <= '0;
                        end else begin
                            r_wait_cnt  <= r_wait_cnt + 4'd1;
                        end
                    end
                    S_LOCKED: begin
                        if (w_match) begin
                            r_miss_cnt <= '0;
                        end else if (r_miss_cnt >= C_LOSE_LAST) begin
                            // Re-search from the current rotation rather than from zero.
                            r_state     <= S_CHECK;
                            r_miss_cnt  <= '0;
                            r_match_cnt <= '0;
                            slip_cnt_o  <= '0;
                            locked_o    <= 1'b0;
                            data_vld_o  <= 1'b0;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iserdes_align_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_iserdes_align_ctrl
// Description : Directed bench for iserdes_align_ctrl (soft, hw and 4-bit).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iserdes_align_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_start, a_bs, a_vld, a_lock, a_fail;
    logic [7:0] a_data, a_do;
    logic [3:0] a_sc;
    logic       b_start, b_bs, b_vld, b_lock, b_fail;
    logic [7:0] b_data, b_do;
    logic [3:0] b_sc;
    logic       c_start, c_bs, c_vld, c_lock, c_fail;
    logic [7:0] c_data, c_do;
    logic [3:0] c_sc;

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
        return (v << n) | (v >> (4'd8 - {1'b0, n}));
    endfunction

    // Deserializer model: output rotates back one position per bitslip.
    logic [2:0] b_off;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)    b_off <= 3'd5;
        else if (b_bs) b_off <= b_off - 3'd1;
    end
    assign b_data = rotl8(8'h5C, b_off);

    iserdes_align_ctrl #(.C_DATA_WIDTH(8), .C_TRAIN_PATTERN(8'h5C), .C_SLIP_MODE("SOFT"),
        .C_WAIT_CYCLES(4), .C_LOCK_CNT(16), .C_LOSE_CNT(4)) dut_a (
        .clk_i(clk), .rstn_i(rst_n), .start_i(a_start), .data_i(a_data),
        .bitslip_o(a_bs), .data_o(a_do), .data_vld_o(a_vld), .locked_o(a_lock),
        .fail_o(a_fail), .slip_cnt_o(a_sc));

    iserdes_align_ctrl #(.C_DATA_WIDTH(8), .C_TRAIN_PATTERN(8'h5C), .C_SLIP_MODE("HW"),
        .C_WAIT_CYCLES(4), .C_LOCK_CNT(16), .C_LOSE_CNT(4)) dut_b (
        .clk_i(clk), .rstn_i(rst_n), .start_i(b_start), .data_i(b_data),
        .bitslip_o(b_bs), .data_o(b_do), .data_vld_o(b_vld), .locked_o(b_lock),
        .fail_o(b_fail), .slip_cnt_o(b_sc));

    iserdes_align_ctrl #(.C_DATA_WIDTH(4), .C_TRAIN_PATTERN(8'h0C), .C_SLIP_MODE("HW"),
        .C_WAIT_CYCLES(4), .C_LOCK_CNT(16), .C_LOSE_CNT(4)) dut_c (
        .clk_i(clk), .rstn_i(rst_n), .start_i(c_start), .data_i(c_data),
        .bitslip_o(c_bs), .data_o(c_do), .data_vld_o(c_vld), .locked_o(c_lock),
        .fail_o(c_fail), .slip_cnt_o(c_sc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scoreboard: expected DATA_O pushed as each word is presented, popped one cycle later.
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];
    int cyc     = 0;
    int last_bs = -100;
    int bs_cnt  = 0;

    initial begin : mon
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                q_b.delete();
                q_c.delete();
            end else begin
                if (q_b.size() > 0) chk("sb_b_data", b_do, q_b.pop_front());
                if (q_c.size() > 0) chk("sb_c_data", c_do, q_c.pop_front());
                q_b.push_back(b_data);
                q_c.push_back({4'h0, c_data[3:0]});
                if (b_bs) begin
                    chk("bs_gap", 32'(cyc - last_bs >= 5), 1);
                    last_bs = cyc;
                    bs_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int         n, wait_end, lock_n, soft_bs;
    logic [2:0] prev_st;

    initial begin : stim
        rst_n = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_data = 8'h00; c_data = 8'h00;
        ticks(2);
        chk("rst_a_outs", {a_bs, a_do, a_vld, a_lock, a_fail, a_sc}, 0);
        chk("rst_b_outs", {b_bs, b_do, b_vld, b_lock, b_fail, b_sc}, 0);
        chk("rst_a_regs", {dut_a.r_state, dut_a.r_match_cnt, dut_a.r_miss_cnt, dut_a.r_rot, dut_a.r_prev}, 0);

        rst_n = 1'b1;
        a_data = 8'hE2;
        ticks(5);
        chk("idle_no_start_state", dut_a.r_state, 3'd0);
        chk("idle_no_start_outs", {a_lock, a_fail, a_sc, a_bs}, 0);

        // Soft alignment: 0xE2 is 0x5C rotated by three positions.
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("soft_start_state", dut_a.r_state, 3'd1);
        wait_end = -1; lock_n = -1; soft_bs = 0; prev_st = 3'd1;
        for (n = 0; n < 300 && !a_lock; n++) begin
            tick();
            if (a_bs) soft_bs++;
            if (prev_st == 3'd3 && dut_a.r_state == 3'd1) wait_end = n;
            if (a_lock) lock_n = n;
            prev_st = dut_a.r_state;
        end
        chk("soft_locked", a_lock, 1);
        chk("soft_slips", a_sc, 3);
        chk("soft_lock_delay", lock_n - wait_end, 16);
        chk("soft_no_bitslip", soft_bs, 0);
        chk("soft_data", {a_vld, a_do}, {1'b1, 8'h5C});

        // Loss of lock: 0xE0 breaks the window, 0xE2 after 0xE0 restores it.
        a_data = 8'hE0;
        tick(); chk("hold_bad1", a_lock, 1);
        tick(); chk("hold_bad2", a_lock, 1);
        tick(); chk("hold_bad3", {a_lock, dut_a.r_miss_cnt}, {1'b1, 4'd3});
        a_data = 8'hE2;
        tick(); chk("good_clears_miss", {a_lock, dut_a.r_miss_cnt}, {1'b1, 4'd0});
        a_data = 8'hE0;
        ticks(3); chk("hold_bad3_again", a_lock, 1);
        tick();
        chk("lock_lost", {a_lock, a_vld}, 0);
        chk("lost_state", dut_a.r_state, 3'd1);
        chk("lost_slipcnt_rot", {a_sc, 1'b0, dut_a.r_rot}, {4'd0, 4'd3});

        // Constant zero stream exhausts all positions.
        a_data = 8'h00;
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("zero_start_clr", {a_sc, dut_a.r_rot}, 0);
        for (n = 0; n < 300 && !a_fail; n++) tick();
        chk("zero_fail", {a_fail, a_lock}, {1'b1, 1'b0});
        chk("zero_slips", a_sc, 7);
        chk("zero_state", dut_a.r_state, 3'd5);
        ticks(10);
        chk("fail_sticky", a_fail, 1);
        a_start = 1'b1; tick(); a_start = 1'b0;
        chk("restart_clears", {a_fail, a_sc}, 0);
        chk("restart_state", dut_a.r_state, 3'd1);

        // 4-bit width: restart collides with the lock-qualifying match.
        c_data = 8'hFC;
        c_start = 1'b1; tick(); c_start = 1'b0;
        for (n = 0; n < 100 && dut_c.r_match_cnt != 8'd15; n++) tick();
        chk("c_pre_cnt", dut_c.r_match_cnt, 15);
        c_start = 1'b1; tick(); c_start = 1'b0;
        chk("c_restart_state", dut_c.r_state, 3'd1);
        chk("c_restart_cnt", dut_c.r_match_cnt, 0);
        chk("c_restart_nolock", c_lock, 0);
        ticks(15);
        chk("c_not_yet_locked", c_lock, 0);
        tick();
        chk("c_locked_data", {c_lock, c_vld, c_do}, {1'b1, 1'b1, 8'h0C});
        chk("c_status", {c_fail, c_sc, c_bs}, 0);

        // Hardware bitslip against the rotating model.
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (n = 0; n < 400 && !b_lock; n++) tick();
        chk("hw_locked", b_lock, 1);
        chk("hw_pulses", bs_cnt, 5);
        chk("hw_slipcnt", b_sc, 5);
        chk("hw_data", {b_vld, b_do}, {1'b1, 8'h5C});
        ticks(30);
        chk("hw_no_slip_after_lock", {b_lock, 28'(bs_cnt)}, {1'b1, 28'd5});

        // Asynchronous reset landing in the SLIP cycle.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (n = 0; n < 50 && !b_bs; n++) tick();
        chk("pre_rst_slip", {b_bs, dut_b.r_state}, {1'b1, 3'd2});
        rst_n = 1'b0;
        #1;
        chk("rst_bs_drop", b_bs, 0);
        chk("rst_mid_outs", {b_bs, b_do, b_vld, b_lock, b_fail, b_sc}, 0);
        chk("rst_mid_state", dut_b.r_state, 3'd0);
        tick();
        rst_n = 1'b1;
        ticks(10);
        chk("post_rst_idle", dut_b.r_state, 3'd0);
        chk("post_rst_outs", {b_bs, b_sc, b_lock, b_fail}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
